cannon_bullet: RTL and testbench

- Player-side stage directly upstream of the invaders block.
- Owns the cannon's horizontal position, launches one bullet at a time on a fire press, and steps the bullet up the screen.
- Drives the bullet coordinates that the invaders block compares against its formation.
- Consumes the invaders block's hit pulse to retire the bullet and accumulate the score.

---
 rtl/cannon_bullet.sv | 185 ++++++++++++++++++
 tb/tb_cannon_bullet.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cannon_bullet.sv
// Player-side cannon and bullet stage feeding the invaders block.
// The cannon walks left/right on a slow tick. One bullet at a time is launched
// from the row just above the cannon and climbs one row per bullet tick. Hits
// reported by the invaders block retire the bullet and add to a saturating
// score. After a bullet retires, the launcher re-arms for a few bullet ticks.
module cannon_bullet #(
  parameter int BULLET_PERIOD  = 25000,
  parameter int CANNON_PERIOD  = 100000,
  parameter int COOLDOWN_TICKS = 4,
  parameter int CANNON_ROW     = 15,
  parameter int MAX_COL        = 19
) (
  input  logic       i_clk_25MHz,
  input  logic       i_reset,
  input  logic       i_fire,
  input  logic       i_left,
  input  logic       i_right,
  input  logic       i_hit,
  output logic [4:0] o_bullet_x,
  output logic [3:0] o_bullet_y,
  output logic       o_bullet_active,
  output logic [4:0] o_cannon_x,
  output logic [7:0] o_score,
  output logic       o_ready
);

  localparam int BW = $clog2(BULLET_PERIOD);
  localparam int CW = $clog2(CANNON_PERIOD);
  localparam int DW = $clog2(COOLDOWN_TICKS + 1);

  localparam logic [BW-1:0] BULLET_LAST = BW'(BULLET_PERIOD - 1);
  localparam logic [CW-1:0] CANNON_LAST = CW'(CANNON_PERIOD - 1);
  localparam logic [DW-1:0] COOL_LAST   = DW'(COOLDOWN_TICKS);
  localparam logic [4:0]    MAX_COL_X   = 5'(MAX_COL);
  localparam logic [4:0]    HOME_X      = 5'(MAX_COL / 2);
  localparam logic [3:0]    SPAWN_Y     = 4'(CANNON_ROW - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FLYING,
    S_COOLDOWN
  } state_t;

  state_t        state_q, state_d;
  logic          fire_q, hit_q;
  logic [CW-1:0] ccnt_q, ccnt_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [DW-1:0] cd_q, cd_d;
  logic [4:0]    cx_q, cx_d;
  logic [4:0]    bx_q, bx_d;
  logic [3:0]    by_q, by_d;
  logic          act_q, act_d;
  logic          rdy_q, rdy_d;
  logic [7:0]    score_q, score_d;

  logic          fire_edge;
  logic          hit_edge;
  logic          cannon_tick;
  logic          bullet_tick;
  logic [7:0]    score_inc;

  // Only the rising edge of each button/flag matters; held levels are inert.
  assign fire_edge   = i_fire & ~fire_q;
  assign hit_edge    = i_hit & ~hit_q;
  assign cannon_tick = (ccnt_q == CANNON_LAST);
  assign bullet_tick = (bcnt_q == BULLET_LAST);
  assign score_inc   = (score_q == 8'hFF) ? 8'hFF : score_q + 8'd1;

  // Cannon timebase and clamped column update, independent of the bullet FSM.
  always_comb begin
    ccnt_d = cannon_tick ? '0 : ccnt_q + CW'(1);
    cx_d   = cx_q;
    if (cannon_tick) begin
      if (i_left && !i_right && (cx_q != 5'd0)) begin
        cx_d = cx_q - 5'd1;
      end else if (i_right && !i_left && (cx_q < MAX_COL_X)) begin
        cx_d = cx_q + 5'd1;
      end
    end
  end

  // Bullet FSM next state: launch, climb, retire on hit or top row, re-arm.
  always_comb begin
    state_d = state_q;
    bcnt_d  = bullet_tick ? '0 : bcnt_q + BW'(1);
    cd_d    = cd_q;
    bx_d    = bx_q;
    by_d    = by_q;
    act_d   = act_q;
    score_d = score_q;
    unique case (state_q)
      S_IDLE: begin
        if (fire_edge) begin
          state_d = S_FLYING;
          bx_d    = cx_q;
          by_d    = SPAWN_Y;
          act_d   = 1'b1;
          bcnt_d  = '0;
        end
      end
      S_FLYING: begin
        // A hit wins over a coincident step so the bullet never moves past
        // the invader it struck.
        if (hit_edge) begin
          score_d = score_inc;
          act_d   = 1'b0;
          by_d    = 4'd0;
          cd_d    = '0;
          state_d = S_COOLDOWN;
        end else if (bullet_tick) begin
          if (by_q == 4'd1) begin
            act_d   = 1'b0;
            by_d    = 4'd0;
            cd_d    = '0;
            state_d = S_COOLDOWN;
          end else begin
            by_d = by_q - 4'd1;
          end
        end
      end
      S_COOLDOWN: begin
        // Late hit reports still count; they arrive after the bullet retired.
        if (hit_edge) begin
          score_d = score_inc;
        end
        if (bullet_tick) begin
          cd_d = cd_q + DW'(1);
          if ((cd_q + DW'(1)) == COOL_LAST) begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    rdy_d = (state_d == S_IDLE);
  end

  // Edge-detect history, cannon timebase and cannon position.
  always_ff @(posedge i_clk_25MHz or posedge i_reset) begin
    if (i_reset) begin
      fire_q <= 1'b0;
      hit_q  <= 1'b0;
      ccnt_q <= '0;
      cx_q   <= HOME_X;
    end else begin
      fire_q <= i_fire;
      hit_q  <= i_hit;
      ccnt_q <= ccnt_d;
      cx_q   <= cx_d;
    end
  end

  // Bullet FSM state, bullet timebase, re-arm counter and registered outputs.
  always_ff @(posedge i_clk_25MHz or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      bcnt_q  <= '0;
      cd_q    <= '0;
      bx_q    <= 5'd0;
      by_q    <= 4'd0;
      act_q   <= 1'b0;
      rdy_q   <= 1'b1;
      score_q <= 8'd0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      cd_q    <= cd_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      act_q   <= act_d;
      rdy_q   <= rdy_d;
      score_q <= score_d;
    end
  end

  assign o_bullet_x      = bx_q;
  assign o_bullet_y      = by_q;
  assign o_bullet_active = act_q;
  assign o_cannon_x      = cx_q;
  assign o_score         = score_q;
  assign o_ready         = rdy_q;

endmodule

// File: tb/tb_cannon_bullet.sv
// Scoreboarded bench for cannon_bullet. A reference model steps on every
// clock edge, works out the expected outputs from launch/retire times using
// plain cycle arithmetic, and queues them; a monitor pops one expectation per
// falling edge and compares it with the DUT.
module tb_cannon_bullet;

  localparam int BP   = 4;
  localparam int CP   = 2;
  localparam int CT   = 2;
  localparam int ROW  = 15;
  localparam int MAXC = 19;

  logic       clk = 1'b0;
  logic       i_reset = 1'b0;
  logic       i_fire = 1'b0;
  logic       i_left = 1'b0;
  logic       i_right = 1'b0;
  logic       i_hit = 1'b0;
  logic [4:0] o_bullet_x;
  logic [3:0] o_bullet_y;
  logic       o_bullet_active;
  logic [4:0] o_cannon_x;
  logic [7:0] o_score;
  logic       o_ready;

  always #5 clk = ~clk;

  cannon_bullet #(
    .BULLET_PERIOD (BP),
    .CANNON_PERIOD (CP),
    .COOLDOWN_TICKS(CT),
    .CANNON_ROW    (ROW),
    .MAX_COL       (MAXC)
  ) dut (
    .i_clk_25MHz    (clk),
    .i_reset        (i_reset),
    .i_fire         (i_fire),
    .i_left         (i_left),
    .i_right        (i_right),
    .i_hit          (i_hit),
    .o_bullet_x     (o_bullet_x),
    .o_bullet_y     (o_bullet_y),
    .o_bullet_active(o_bullet_active),
    .o_cannon_x     (o_cannon_x),
    .o_score        (o_score),
    .o_ready        (o_ready)
  );

  typedef struct packed {
    logic [4:0] bx;
    logic [3:0] by;
    logic       act;
    logic [4:0] cx;
    logic [7:0] sc;
    logic       rdy;
  } snap_t;

  localparam snap_t RESET_SNAP = '{bx: 5'd0, by: 4'd0, act: 1'b0,
                                   cx: 5'd9, sc: 8'd0, rdy: 1'b1};

  snap_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  // Reference model state: edge index since reset, launch anchor of the
  // bullet timebase, edge at which re-arming completes.
  int m_n, m_anchor, m_cool_end, m_cx, m_bx, m_by, m_score;
  bit m_fly, m_fire_prev, m_hit_prev;

  task automatic model_reset();
    m_n = 0; m_anchor = 0; m_cool_end = 0;
    m_cx = MAXC / 2; m_bx = 0; m_by = 0; m_score = 0;
    m_fly = 0; m_fire_prev = 0; m_hit_prev = 0;
  endtask

  function automatic snap_t model_snap();
    snap_t s;
    s.bx  = 5'(m_bx);
    s.by  = 4'(m_by);
    s.act = m_fly;
    s.cx  = 5'(m_cx);
    s.sc  = 8'(m_score);
    s.rdy = !m_fly && (m_n >= m_cool_end);
    return s;
  endfunction

  // Re-arm completes on the CT-th bullet tick strictly after the retire edge.
  task automatic model_retire(input string why);
    m_fly = 0;
    m_by  = 0;
    m_cool_end = m_anchor + BP * ((m_n - m_anchor) / BP + 1) + (CT - 1) * BP;
    $display("retire (%s) at edge %0d score=%0d ready at edge %0d", why, m_n, m_score, m_cool_end);
  endtask

  task automatic model_step();
    bit fe, he, tick;
    int cx_old;
    m_n++;
    fe = i_fire && !m_fire_prev;
    he = i_hit && !m_hit_prev;
    m_fire_prev = i_fire;
    m_hit_prev  = i_hit;
    tick   = (m_n > m_anchor) && (((m_n - m_anchor) % BP) == 0);
    cx_old = m_cx;
    if (m_fly) begin
      if (he) begin
        m_score = (m_score < 255) ? m_score + 1 : 255;
        model_retire("hit");
      end else if (tick && m_by == 1) begin
        model_retire("miss");
      end else if (tick) begin
        m_by--;
      end
    end else if (m_n <= m_cool_end) begin
      if (he) m_score = (m_score < 255) ? m_score + 1 : 255;
    end else if (fe) begin
      m_fly = 1;
      m_bx = cx_old;
      m_by = ROW - 1;
      m_anchor = m_n;
      $display("launch at edge %0d x=%0d", m_n, m_bx);
    end
    if ((m_n % CP) == 0) begin
      if (i_left && !i_right) m_cx = (m_cx > 0) ? m_cx - 1 : 0;
      else if (i_right && !i_left) m_cx = (m_cx < MAXC) ? m_cx + 1 : MAXC;
    end
  endtask

  // Model: one expectation per clock edge; an asynchronous reset replaces
  // the pending expectation of the current cycle with the reset state.
  always @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      model_reset();
      exp_q.delete();
      if (clk) exp_q.push_back(model_snap());
    end else begin
      model_step();
      exp_q.push_back(model_snap());
    end
  end

  function automatic void compare(input snap_t e, input string tag);
    snap_t a;
    a = {o_bullet_x, o_bullet_y, o_bullet_active, o_cannon_x, o_score, o_ready};
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s t=%0t: got bx=%0d by=%0d act=%0b cx=%0d score=%0d rdy=%0b, required bx=%0d by=%0d act=%0b cx=%0d score=%0d rdy=%0b",
               tag, $time, a.bx, a.by, a.act, a.cx, a.sc, a.rdy,
               e.bx, e.by, e.act, e.cx, e.sc, e.rdy);
    end
  endfunction

  // Monitor: compares on every falling edge, and right after any reset
  // assertion to confirm the outputs cleared without a clock edge.
  bit    rst_seen = 1'b0;
  snap_t mon_e;
  always @(negedge clk or posedge i_reset) begin
    if (i_reset && !rst_seen) begin
      rst_seen = 1'b1;
      #1;
      compare(RESET_SNAP, "async_reset");
    end else begin
      if (!i_reset) rst_seen = 1'b0;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        compare(mon_e, "cycle");
      end
    end
  end

  task automatic cycles(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Reset asserted between a rising and falling edge, released on a falling edge.
  task automatic async_reset(input int hold);
    @(posedge clk);
    #2 i_reset = 1'b1;
    cycles(hold);
    i_reset = 1'b0;
  endtask

  initial begin
    #1 i_reset = 1'b1;
    cycles(3);
    i_reset = 1'b0;
    cycles(5);

    // Walk right into the clamp, then press both buttons at the edge.
    i_right = 1'b1;
    cycles(30);
    i_left = 1'b1;
    cycles(8);
    i_left = 1'b0;
    i_right = 1'b0;

    // Bring the cannon home and fly one bullet all the way to a miss.
    async_reset(2);
    cycles(3);
    i_fire = 1'b1;
    cycles(1);
    i_fire = 1'b0;
    cycles(70);

    // Hit held three cycles, rising on the tick that would step y 5 -> 4,
    // then a fire press during re-arm.
    i_fire = 1'b1;
    cycles(1);
    i_fire = 1'b0;
    cycles(39);
    i_hit = 1'b1;
    cycles(3);
    i_hit = 1'b0;
    i_fire = 1'b1;
    cycles(1);
    i_fire = 1'b0;
    cycles(12);

    // Launch/hit loop drives the score into saturation.
    for (int k = 0; k < 256; k++) begin
      i_left  = ($urandom_range(0, 3) == 0);
      i_right = ($urandom_range(0, 3) == 0);
      i_fire = 1'b1;
      cycles(1);
      i_fire = 1'b0;
      cycles($urandom_range(1, 3));
      i_hit = 1'b1;
      cycles($urandom_range(1, 2));
      i_hit = 1'b0;
      cycles(10);
    end

    // Free random traffic on every input.
    for (int k = 0; k < 1500; k++) begin
      i_left  = ($urandom_range(0, 3) == 0);
      i_right = ($urandom_range(0, 3) == 0);
      i_fire  = ($urandom_range(0, 4) == 0);
      i_hit   = ($urandom_range(0, 5) == 0);
      cycles(1);
    end
    i_left = 1'b0;
    i_right = 1'b0;
    i_fire = 1'b0;
    i_hit = 1'b0;
    cycles(70);

    // Reset mid-flight at y=7 with fire held through it.
    i_fire = 1'b1;
    cycles(1);
    cycles(27);
    async_reset(3);
    cycles(80);
    i_fire = 1'b0;
    cycles(5);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
